// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the single-port RAM controller blocks.
// Holds the arbiter FSM encoding and default bus widths.
package ram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_REQ    = 3;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 8;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first set req bit at or above pointer, wrapping to 0.
// Latency: combinational. Backpressure: none, the caller decides when to use the winner.
// Winner is all-zero when no req bit is set.
module rr_select
   import ram_ctrl_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int PTR_W   = ptr_width(DEF_NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   pointer,
   output logic [NUM_REQ-1:0] winner
);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = PTR_W'((int'(pointer) + i) % NUM_REQ);
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port among NUM_REQ requesters, round-robin, one access at a time.
// Latency: grant 1 cycle after req is seen, rd_valid 1 cycle after grant for reads.
// Backpressure: req is a level held until grant; requests are only sampled in IDLE.
module ram_port_arbiter
   import ram_ctrl_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_write_enable,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            rd_valid,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          ram_write_enable,
   output logic [ADDR_WIDTH-1:0]         ram_address,
   output logic [DATA_WIDTH-1:0]         ram_data_in,
   input  logic [DATA_WIDTH-1:0]         ram_data_out
);

   localparam int PTR_W = ptr_width(NUM_REQ);

   arb_state_t           state;
   logic [PTR_W-1:0]     rr_ptr;
   logic [NUM_REQ-1:0]   win_oh;
   logic                 win_we;

   logic [NUM_REQ-1:0]   sel_oh;
   logic [PTR_W-1:0]     sel_idx;
   logic [PTR_W-1:0]     next_ptr;
   logic                 sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;

   rr_select #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_select (
      .req     (req),
      .pointer (rr_ptr),
      .winner  (sel_oh)
   );

   // One-hot mux of the winner's fields; constant slices keep indexing simple.
   always_comb begin
      sel_idx  = '0;
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel_oh[i]) begin
            sel_idx  = PTR_W'(i);
            sel_we   = req_write_enable[i];
            sel_addr = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign next_ptr = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);

   // The RAM output register is only meaningful in RESP, so it is gated to the pulse.
   assign rd_data = (|rd_valid) ? ram_data_out : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         rr_ptr           <= '0;
         win_oh           <= '0;
         win_we           <= 1'b0;
         grant            <= '0;
         rd_valid         <= '0;
         ram_write_enable <= 1'b0;
         ram_address      <= '0;
         ram_data_in      <= '0;
      end else begin
         case (state)
            IDLE: begin
               rd_valid <= '0;
               if (|req) begin
                  state            <= ISSUE;
                  grant            <= sel_oh;
                  win_oh           <= sel_oh;
                  win_we           <= sel_we;
                  ram_write_enable <= sel_we;
                  ram_address      <= sel_addr;
                  ram_data_in      <= sel_data;
                  rr_ptr           <= next_ptr;
               end
            end
            ISSUE: begin
               grant            <= '0;
               ram_write_enable <= 1'b0;
               if (win_we) begin
                  state <= IDLE;
               end else begin
                  state    <= RESP;
                  rd_valid <= win_oh;
               end
            end
            RESP: begin
               rd_valid <= '0;
               state    <= IDLE;
            end
            default: begin
               grant            <= '0;
               rd_valid         <= '0;
               ram_write_enable <= 1'b0;
               state            <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural registered-read RAM.
module tb_ram_port_arbiter;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  req = '0;
   logic [2:0]  req_write_enable = '0;
   logic [23:0] req_address = '0;
   logic [23:0] req_data_in = '0;
   logic [2:0]  grant;
   logic [2:0]  rd_valid;
   logic [7:0]  rd_data;
   logic        ram_write_enable;
   logic [7:0]  ram_address;
   logic [7:0]  ram_data_in;
   logic [7:0]  ram_data_out = '0;

   logic [7:0]  mem [256];

   typedef struct {
      logic [2:0] gnt;
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
      int         cyc;
   } gnt_exp_t;

   typedef struct {
      logic [2:0] vld;
      logic [7:0] data;
      int         cyc;
   } rd_exp_t;

   gnt_exp_t gq[$];
   rd_exp_t  rq[$];

   int cyc;
   int checks;
   int errors;

   ram_port_arbiter dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .req              (req),
      .req_write_enable (req_write_enable),
      .req_address      (req_address),
      .req_data_in      (req_data_in),
      .grant            (grant),
      .rd_valid         (rd_valid),
      .rd_data          (rd_data),
      .ram_write_enable (ram_write_enable),
      .ram_address      (ram_address),
      .ram_data_in      (ram_data_in),
      .ram_data_out     (ram_data_out)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (ram_write_enable) mem[ram_address] <= ram_data_in;
      ram_data_out <= mem[ram_address];
   end

   // Scoreboard: every grant / rd_valid pulse must match the head of its queue.
   always @(negedge clock) begin
      if (reset_n) begin
         gnt_exp_t ge;
         rd_exp_t  re;
         checks++;
         if ((grant != 0 && rd_valid != 0) || $countones(grant) > 1 || $countones(rd_valid) > 1) begin
            errors++;
            $display("FAIL exclusive cyc=%0d grant=%b rd_valid=%b required one-hot and not both", cyc, grant, rd_valid);
         end
         checks++;
         if (grant == 0 && ram_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL we_outside_issue cyc=%0d ram_write_enable=%b required 0", cyc, ram_write_enable);
         end
         if (grant != 0) begin
            checks++;
            if (gq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_grant cyc=%0d grant=%b required none", cyc, grant);
            end else begin
               ge = gq.pop_front();
               if (grant !== ge.gnt || ram_write_enable !== ge.we || ram_address !== ge.addr ||
                   ram_data_in !== ge.data || cyc != ge.cyc) begin
                  errors++;
                  $display("FAIL grant cyc=%0d got g=%b we=%b a=%h d=%h, required cyc=%0d g=%b we=%b a=%h d=%h",
                           cyc, grant, ram_write_enable, ram_address, ram_data_in,
                           ge.cyc, ge.gnt, ge.we, ge.addr, ge.data);
               end
            end
         end
         if (rd_valid != 0) begin
            checks++;
            if (rq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_rd_valid cyc=%0d rd_valid=%b required none", cyc, rd_valid);
            end else begin
               re = rq.pop_front();
               if (rd_valid !== re.vld || rd_data !== re.data || cyc != re.cyc) begin
                  errors++;
                  $display("FAIL rd_valid cyc=%0d got v=%b d=%h, required cyc=%0d v=%b d=%h",
                           cyc, rd_valid, rd_data, re.cyc, re.vld, re.data);
               end
            end
         end
      end
   end

   task automatic drain(input string name);
      repeat (5) @(posedge clock);
      #1;
      checks++;
      if (gq.size() != 0 || rq.size() != 0) begin
         errors++;
         $display("FAIL %s_drain pending grants=%0d reads=%0d required 0 0", name, gq.size(), rq.size());
         gq.delete();
         rq.delete();
      end
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if (grant !== 0 || rd_valid !== 0 || rd_data !== 0 || ram_write_enable !== 0 ||
          ram_address !== 0 || ram_data_in !== 0) begin
         errors++;
         $display("FAIL %s g=%b v=%b rd=%h we=%b a=%h d=%h required all 0",
                  name, grant, rd_valid, rd_data, ram_write_enable, ram_address, ram_data_in);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check_outputs_zero("reset_state");
      @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_fairness();
      req_write_enable = 3'b111;
      req_address = {8'h22, 8'h21, 8'h20};
      req_data_in = {8'h32, 8'h31, 8'h30};
      req = 3'b111;
      gq.push_back('{3'b001, 1'b1, 8'h20, 8'h30, cyc + 1});
      gq.push_back('{3'b010, 1'b1, 8'h21, 8'h31, cyc + 3});
      gq.push_back('{3'b100, 1'b1, 8'h22, 8'h32, cyc + 5});
      gq.push_back('{3'b001, 1'b1, 8'h20, 8'h30, cyc + 7});
      repeat (7) @(posedge clock);
      #1 req = '0;
      drain("fairness");
   endtask

   task automatic test_single_write();
      req_write_enable = 3'b001;
      req_address = {8'h00, 8'h00, 8'h10};
      req_data_in = {8'h00, 8'h00, 8'hA5};
      req = 3'b001;
      gq.push_back('{3'b001, 1'b1, 8'h10, 8'hA5, cyc + 1});
      @(posedge clock);
      #1 req = '0;
      drain("single_write");
      @(negedge clock);
      checks++;
      if (ram_write_enable !== 1'b0 || ram_address !== 8'h10 || ram_data_in !== 8'hA5) begin
         errors++;
         $display("FAIL hold_after_write we=%b a=%h d=%h required 0 10 a5", ram_write_enable, ram_address, ram_data_in);
      end
   endtask

   task automatic test_read_back();
      @(posedge clock);
      #1;
      req_write_enable = 3'b000;
      req_address = {8'h00, 8'h10, 8'h00};
      req_data_in = '0;
      req = 3'b010;
      gq.push_back('{3'b010, 1'b0, 8'h10, 8'h00, cyc + 1});
      rq.push_back('{3'b010, 8'hA5, cyc + 2});
      @(posedge clock);
      #1 req = '0;
      drain("read_back");
   endtask

   task automatic test_wrap();
      // pointer is 2 here after the requester-1 read
      req_write_enable = 3'b101;
      req_address = {8'h42, 8'h00, 8'h40};
      req_data_in = {8'h52, 8'h00, 8'h50};
      req = 3'b101;
      gq.push_back('{3'b100, 1'b1, 8'h42, 8'h52, cyc + 1});
      gq.push_back('{3'b001, 1'b1, 8'h40, 8'h50, cyc + 3});
      @(posedge clock);
      #1 req = 3'b001;
      repeat (2) @(posedge clock);
      #1 req = '0;
      drain("wrap");
   endtask

   task automatic test_withdrawal();
      int g2 = 0;
      req_write_enable = 3'b100;
      req_address = {8'h77, 8'h00, 8'h40};
      req_data_in = {8'h99, 8'h00, 8'h00};
      req = 3'b001;
      gq.push_back('{3'b001, 1'b0, 8'h40, 8'h00, cyc + 1});
      rq.push_back('{3'b001, 8'h50, cyc + 2});
      @(posedge clock);
      #1 req = '0;
      @(posedge clock);
      #1 req = 3'b100;
      @(posedge clock);
      #1 req = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (grant[2]) g2++;
      end
      checks++;
      if (g2 != 0) begin
         errors++;
         $display("FAIL withdrawal grants_to_req2=%0d required 0", g2);
      end
      drain("withdrawal");
   endtask

   task automatic test_reset_mid_read();
      req_write_enable = 3'b000;
      req_address = {8'h00, 8'h10, 8'h00};
      req_data_in = '0;
      req = 3'b010;
      @(posedge clock);
      #1;
      checks++;
      if (grant !== 3'b010) begin
         errors++;
         $display("FAIL mid_read_grant grant=%b required 010", grant);
      end
      req = '0;
      reset_n = 1'b0;
      #1 check_outputs_zero("reset_mid_issue");
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      req_write_enable = 3'b011;
      req_address = {8'h00, 8'h61, 8'h60};
      req_data_in = {8'h00, 8'h71, 8'h70};
      req = 3'b011;
      gq.push_back('{3'b001, 1'b1, 8'h60, 8'h70, cyc + 1});
      gq.push_back('{3'b010, 1'b1, 8'h61, 8'h71, cyc + 3});
      @(posedge clock);
      #1 req = 3'b010;
      repeat (2) @(posedge clock);
      #1 req = '0;
      drain("reset_mid_read");
   endtask

   task automatic test_back_to_back_reads();
      // pointer is 2 after the post-reset writes; two readers queue up
      req_write_enable = 3'b000;
      req_address = {8'h61, 8'h00, 8'h60};
      req_data_in = '0;
      req = 3'b101;
      gq.push_back('{3'b100, 1'b0, 8'h61, 8'h00, cyc + 1});
      rq.push_back('{3'b100, 8'h71, cyc + 2});
      gq.push_back('{3'b001, 1'b0, 8'h60, 8'h00, cyc + 4});
      rq.push_back('{3'b001, 8'h70, cyc + 5});
      @(posedge clock);
      #1 req = 3'b001;
      repeat (3) @(posedge clock);
      #1 req = '0;
      drain("back_to_back_reads");
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_single_write();
      test_read_back();
      test_wrap();
      test_withdrawal();
      test_reset_mid_read();
      test_back_to_back_reads();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout cyc=%0d required completion", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, 3, number of requesters sharing one RAM port.
REQ-002 Parameter ADDR_WIDTH, 8, RAM address width.
REQ-003 Parameter DATA_WIDTH, 8, RAM data width.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  NUM_REQ  per-requester access request, level, held until grant.
REQ-007 req_write_enable  in  NUM_REQ  per-requester write enable (1 = write, 0 = read).
REQ-008 req_address  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies slice i.
REQ-009 req_data_in  in  NUM_REQ*DATA_WIDTH  flattened write data; requester i occupies slice i.
REQ-010 grant  out  NUM_REQ  one-hot, one-cycle pulse; access issued to RAM this cycle.
REQ-011 rd_valid  out  NUM_REQ  one-hot, one-cycle pulse; rd_data is valid for that requester.
REQ-012 rd_data  out  DATA_WIDTH  read data returned to the granted reader.
REQ-013 ram_write_enable  out  1  drives the RAM port write_enable.
REQ-014 ram_address  out  ADDR_WIDTH  drives the RAM port address.
REQ-015 ram_data_in  out  DATA_WIDTH  drives the RAM port data_in.
REQ-016 ram_data_out  in  DATA_WIDTH  RAM port data_out; registered, valid one cycle after the read edge.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE and RESP.
REQ-018 In IDLE with any req bit set, the block SHALL select a winner round-robin, starting at the rr pointer and searching upward with wrap-around, then enter ISSUE.
REQ-019 In ISSUE, grant[winner], ram_address, ram_data_in and ram_write_enable SHALL be driven from registered copies of the winner's fields, for exactly one cycle.
REQ-020 Latency SHALL be: req seen in cycle N, grant in cycle N+1; for a read, rd_valid in cycle N+2.
REQ-021 From ISSUE, a write SHALL return to IDLE; a read SHALL go to RESP.
REQ-022 In RESP, rd_valid[winner] SHALL pulse with rd_data = ram_data_out, then the FSM SHALL return to IDLE.
REQ-023 After each grant, the rr pointer SHALL become (winner+1) mod NUM_REQ.
REQ-024 A req deasserted before its grant SHALL be treated as withdrawn; no grant is issued to it.
REQ-025 Changes to req or its fields during ISSUE or RESP SHALL NOT affect the committed access.
REQ-026 Throughput SHALL be at most one write per 2 cycles and one read per 3 cycles.
REQ-027 Outside ISSUE, ram_write_enable SHALL be 0; ram_address and ram_data_in SHALL hold their last values.
REQ-028 grant and rd_valid SHALL never have more than one bit set, and SHALL never both be nonzero in the same cycle.

Reset
REQ-029 While reset_n = 0: FSM is IDLE, rr pointer is 0, and grant, rd_valid, rd_data, ram_write_enable, ram_address and ram_data_in are all 0.
REQ-030 Reset asserted during ISSUE or RESP SHALL abort the access; no rd_valid is produced afterward for it.
REQ-031 After reset_n rises, the first arbitration SHALL occur on the next rising edge.

Structure
REQ-032 FSM state encodings and default width constants SHALL live in shared package ram_ctrl_pkg.
REQ-033 Round-robin selection SHALL be one combinational sub-module, rr_select (inputs: req, pointer; output: one-hot winner).
REQ-034 The RAM itself SHALL be instantiated outside this block; this block drives one RAM port only.

Verification
REQ-035 Single write: req=001, we=1, addr=0x10, data=0xA5 -> grant=001 one cycle later with ram_write_enable=1, addr=0x10, data=0xA5; no rd_valid.
REQ-036 Read-back: requester 1 reads 0x10 after REQ-035 -> grant=010 at N+1, rd_valid=010 with rd_data=0xA5 at N+2.
REQ-037 Fairness: req=111 held continuously, all writes -> grant sequence 001,010,100,001, with each grant separated by one idle cycle.
REQ-038 Withdrawal: requester 2 raises req for one cycle while a read is in RESP -> no grant ever issued to requester 2.
REQ-039 Reset mid-read: reset_n=0 during ISSUE of a read -> all outputs 0; no rd_valid after release; next grant starts from requester 0.
REQ-040 Wrap: pointer=2, req=101 -> grant=100 first, then 001.
